// File: rtl/jump_physics.sv
// jump_physics: frame-ticked jump / gravity integrator for a sprite's vertical axis.
// Optional double jump is compiled in when the macro JUMP_DOUBLE_EN is defined.
module jump_physics #(
  parameter int VEL_W     = 10,
  parameter int Y_W       = 10,
  parameter int V0        = 10,
  parameter int GRAV_STEP = 2,
  parameter int HOLD      = 2,
  parameter int V_MAX     = 10,
  parameter int GROUND_Y  = 400
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic                    jump_req,
  output logic signed [VEL_W-1:0] velocity,
  output logic        [Y_W-1:0]   y_pos,
  output logic                    on_ground,
  output logic                    landed,
  output logic                    apex
);
  localparam int PW = Y_W + 2;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic signed [VEL_W-1:0] LAUNCH_V  = VEL_W'(-V0);
  localparam logic signed [VEL_W:0]   GRAV_V    = (VEL_W+1)'(GRAV_STEP);
  localparam logic signed [VEL_W:0]   VMAX_V    = (VEL_W+1)'(V_MAX);
  localparam logic signed [PW-1:0]    GROUND_P  = PW'(GROUND_Y);
  localparam logic        [Y_W-1:0]   GROUND_U  = Y_W'(GROUND_Y);
  localparam logic        [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RISE, FALL, LAND} state_t;

  state_t                  state, state_n;
  logic signed [VEL_W-1:0] vel_n;
  logic        [Y_W-1:0]   y_n;
  logic        [HW-1:0]    hold_cnt, hold_n;
  logic                    landed_n, apex_n;
  logic signed [PW-1:0]    y_sum;
  logic signed [VEL_W:0]   vel_step;
  logic                    relaunch;

`ifdef JUMP_DOUBLE_EN
  logic jump_q, pending, used;
  logic rise_edge, airborne, airborne_n;

  assign rise_edge  = jump_req & ~jump_q;
  assign airborne   = (state == RISE) || (state == FALL);
  assign airborne_n = (state_n == RISE) || (state_n == FALL);
  assign relaunch   = pending & ~used;

  // Edge detect and pending flag run every Clk; the pending flag is consumed on the next tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      jump_q  <= 1'b0;
      pending <= 1'b0;
      used    <= 1'b0;
    end else begin
      jump_q <= jump_req;
      if (frame_tick) begin
        pending <= rise_edge & airborne_n;
        if (state_n == LAND)
          used <= 1'b0;
        else if (airborne && relaunch)
          used <= 1'b1;
      end else if (rise_edge && airborne) begin
        pending <= 1'b1;
      end
    end
  end
`else
  assign relaunch = 1'b0;
`endif

  assign on_ground = Reset || (state == IDLE) || (state == LAND);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    state_n  = state;
    vel_n    = velocity;
    y_n      = y_pos;
    hold_n   = hold_cnt;
    landed_n = 1'b0;
    apex_n   = 1'b0;
    y_sum    = $signed({2'b00, y_pos}) + PW'(velocity);
    vel_step = (VEL_W+1)'(velocity) + GRAV_V;
    if (frame_tick) begin
      case (state)
        IDLE: if (jump_req) begin
          state_n = RISE;
          vel_n   = LAUNCH_V;
          hold_n  = '0;
        end
        RISE: begin
          if (relaunch) begin
            vel_n  = LAUNCH_V;
            hold_n = '0;
          end else if (y_sum < 0) begin
            y_n     = '0;
            vel_n   = '0;
            hold_n  = '0;
            state_n = FALL;
            apex_n  = 1'b1;
          end else begin
            y_n = y_sum[Y_W-1:0];
            if (hold_cnt == HOLD_LAST) begin
              hold_n = '0;
              if (vel_step >= 0) begin
                vel_n   = '0;
                state_n = FALL;
                apex_n  = 1'b1;
              end else begin
                vel_n = vel_step[VEL_W-1:0];
              end
            end else begin
              hold_n = hold_cnt + HW'(1);
            end
          end
        end
        FALL: begin
          // Ground contact wins over both gravity and a pending double jump.
          if (y_sum >= GROUND_P) begin
            y_n      = GROUND_U;
            vel_n    = '0;
            hold_n   = '0;
            state_n  = LAND;
            landed_n = 1'b1;
          end else if (relaunch) begin
            vel_n   = LAUNCH_V;
            hold_n  = '0;
            state_n = RISE;
          end else begin
            y_n = y_sum[Y_W-1:0];
            if (hold_cnt == HOLD_LAST) begin
              hold_n = '0;
              vel_n  = (vel_step > VMAX_V) ? VMAX_V[VEL_W-1:0] : vel_step[VEL_W-1:0];
            end else begin
              hold_n = hold_cnt + HW'(1);
            end
          end
        end
        LAND: if (!jump_req) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      y_pos    <= GROUND_U;
      velocity <= '0;
      hold_cnt <= '0;
      landed   <= 1'b0;
      apex     <= 1'b0;
    end else begin
      state    <= state_n;
      y_pos    <= y_n;
      velocity <= vel_n;
      hold_cnt <= hold_n;
      landed   <= landed_n;
      apex     <= apex_n;
    end
  end
endmodule

// File: tb/tb_jump_physics.sv
// Self-checking bench for jump_physics: three parameterisations driven by one stimulus
// stream and compared every Clk against a tick-level trajectory model.
module tb_jump_physics;
  localparam int HOLD_T = 2;
  localparam int GRAV_T = 2;
  localparam int V0_T   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic jump_req = 1'b0;

  always #5 clk = ~clk;

  logic signed [9:0] vel0, vel1, vel2;
  logic        [9:0] y0, y1, y2;
  logic              g0, g1, g2, l0, l1, l2, a0, a1, a2;

  jump_physics dut0 (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .jump_req(jump_req),
    .velocity(vel0), .y_pos(y0), .on_ground(g0), .landed(l0), .apex(a0)
  );
  jump_physics #(.GROUND_Y(30)) dut1 (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .jump_req(jump_req),
    .velocity(vel1), .y_pos(y1), .on_ground(g1), .landed(l1), .apex(a1)
  );
  jump_physics #(.V_MAX(4)) dut2 (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .jump_req(jump_req),
    .velocity(vel2), .y_pos(y2), .on_ground(g2), .landed(l2), .apex(a2)
  );

  // Trajectory model: airborne/rising flags plus a "key must be released" latch after landing.
  typedef struct {
    int y; int v; int h;
    bit air; bit up; bit wait_rel; bit used; bit pend; bit prev;
    bit landed; bit apex;
  } mdl_t;

  mdl_t m0, m1, m2;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic mdl_t mdl_reset(input int gy);
    mdl_t n;
    n = '{default: 0};
    n.y = gy;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit tick, input bit jr,
                                    input int gy, input int vmax);
    mdl_t n;
    int   ny;
    bit   relaunch;
    n = m;
    n.landed = 1'b0;
    n.apex = 1'b0;
    n.prev = jr;
    relaunch = 1'b0;
`ifdef JUMP_DOUBLE_EN
    relaunch = m.pend && !m.used;
    if (!tick) begin
      if (jr && !m.prev && m.air) n.pend = 1'b1;
      return n;
    end
`endif
    if (!tick) return n;
    if (!m.air) begin
      if (m.wait_rel) begin
        if (!jr) n.wait_rel = 1'b0;
      end else if (jr) begin
        n.air = 1'b1; n.up = 1'b1; n.v = -V0_T; n.h = 0;
      end
    end else begin
      ny = m.y + m.v;
      if (!m.up && ny >= gy) begin
        n.y = gy; n.v = 0; n.h = 0; n.air = 1'b0; n.wait_rel = 1'b1;
        n.landed = 1'b1; n.used = 1'b0;
      end else if (relaunch) begin
        n.v = -V0_T; n.h = 0; n.up = 1'b1; n.used = 1'b1;
      end else if (m.up && ny < 0) begin
        n.y = 0; n.v = 0; n.h = 0; n.up = 1'b0; n.apex = 1'b1;
      end else begin
        n.y = ny;
        if (m.h == HOLD_T - 1) begin
          n.h = 0;
          n.v = m.v + GRAV_T;
          if (m.up && n.v >= 0) begin
            n.v = 0; n.up = 1'b0; n.apex = 1'b1;
          end else if (!m.up && n.v > vmax) begin
            n.v = vmax;
          end
        end else begin
          n.h = m.h + 1;
        end
      end
    end
`ifdef JUMP_DOUBLE_EN
    n.pend = jr && !m.prev && n.air;
`endif
    return n;
  endfunction

  task automatic compare_all();
    check("d0.y", int'(y0), m0.y);
    check("d0.vel", int'(vel0), m0.v);
    check("d0.ground", int'(g0), int'(!m0.air));
    check("d0.landed", int'(l0), int'(m0.landed));
    check("d0.apex", int'(a0), int'(m0.apex));
    check("d1.y", int'(y1), m1.y);
    check("d1.vel", int'(vel1), m1.v);
    check("d1.ground", int'(g1), int'(!m1.air));
    check("d1.landed", int'(l1), int'(m1.landed));
    check("d1.apex", int'(a1), int'(m1.apex));
    check("d2.y", int'(y2), m2.y);
    check("d2.vel", int'(vel2), m2.v);
    check("d2.ground", int'(g2), int'(!m2.air));
    check("d2.landed", int'(l2), int'(m2.landed));
    check("d2.apex", int'(a2), int'(m2.apex));
    check("d2.vmax", int'(vel2 > 10'sd4), 0);
    if (l2) check("d2.touchdown", int'(y2), 400);
  endtask

  task automatic cycle(input bit t, input bit j);
    frame_tick = t;
    jump_req = j;
    @(posedge clk);
    #1;
    m0 = mdl_step(m0, t, j, 400, 10);
    m1 = mdl_step(m1, t, j, 30, 10);
    m2 = mdl_step(m2, t, j, 400, 4);
    compare_all();
    frame_tick = 1'b0;
  endtask

  // A few idle Clks with the key at level j, then one frame tick.
  task automatic tick(input bit j);
    int gap;
    gap = $urandom_range(1, 3);
    repeat (gap) cycle(1'b0, j);
    cycle(1'b1, j);
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    jump_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m0 = mdl_reset(400);
    m1 = mdl_reset(30);
    m2 = mdl_reset(400);
  endtask

  initial begin
    int ytab[10];
    ytab = '{390, 380, 372, 364, 358, 352, 348, 344, 342, 340};
    m0 = mdl_reset(400);
    m1 = mdl_reset(30);
    m2 = mdl_reset(400);

    #12;
    check("rst.y", int'(y0), 400);
    check("rst.vel", int'(vel0), 0);
    check("rst.ground", int'(g0), 1);
    check("rst.landed", int'(l0), 0);
    check("rst.apex", int'(a0), 0);
    check("rst.y_ceil", int'(y1), 30);
    do_reset();

    // Reference trajectory with default parameters.
    tick(1'b1);
    check("launch.vel", int'(vel0), -10);
    check("launch.y", int'(y0), 400);
    for (int n = 2; n <= 11; n++) begin
      tick(1'b0);
      check("traj.y", int'(y0), ytab[n-2]);
      check("traj.apex", int'(a0), int'(n == 11));
      if (n == 5) begin
        check("ceil.y", int'(y1), 0);
        check("ceil.apex", int'(a1), 1);
        check("ceil.vel", int'(vel1), 0);
      end
    end
    for (int n = 12; n <= 23; n++) begin
      tick(1'b0);
      check("traj.landed", int'(l0), int'(n == 23));
    end
    check("touch.y", int'(y0), 400);
    check("touch.ground", int'(g0), 1);
    tick(1'b0);

    // Reset mid-jump aborts straight to the ground.
    do_reset();
    tick(1'b1);
    for (int n = 2; n <= 7; n++) tick(1'b0);
    check("abort.pre_y", int'(y0), 352);
    #2 rst = 1'b1;
    #1;
    check("abort.y", int'(y0), 400);
    check("abort.vel", int'(vel0), 0);
    check("abort.ground", int'(g0), 1);
    check("abort.landed", int'(l0), 0);
    do_reset();
    check("abort.landed_after", int'(l0), 0);

    // Key held through landing never re-launches.
    repeat (30) tick(1'b1);
    check("held.ground", int'(g0), 1);
    check("held.y", int'(y0), 400);
    check("held.vel", int'(vel0), 0);
    tick(1'b0);
    check("release.ground", int'(g0), 1);
    tick(1'b1);
    check("repress.vel", int'(vel0), -10);
    check("repress.ground", int'(g0), 0);
    repeat (26) tick(1'b0);
    check("repress.landed_home", int'(g0), 1);

    // Second press near the apex, then a third press.
    do_reset();
    tick(1'b1);
    for (int n = 2; n <= 9; n++) tick(1'b0);
    check("dbl.pre_y", int'(y0), 344);
    tick(1'b1);
`ifdef JUMP_DOUBLE_EN
    check("dbl.vel", int'(vel0), -10);
    check("dbl.y", int'(y0), 344);
`else
    check("dbl.vel", int'(vel0), -2);
    check("dbl.y", int'(y0), 342);
`endif
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
`ifdef JUMP_DOUBLE_EN
    check("third.y", int'(y0), 316);
    check("third.vel", int'(vel0), -8);
`else
    check("third.y", int'(y0), 340);
    check("third.vel", int'(vel0), 2);
`endif
    repeat (40) tick(1'b0);
    check("dbl.home", int'(g0), 1);

    // Randomised key activity checked against the model every Clk.
    do_reset();
    repeat (300) tick($urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jump_physics.md
JUMP_PHYSICS -- requirements
Module: jump_physics

Interface
REQ-001 SHALL provide parameter VEL_W, default 10, width of the signed velocity output.
REQ-002 SHALL provide parameter Y_W, default 10, width of the unsigned vertical position.
REQ-003 SHALL provide parameter V0, default 10, launch speed; launch velocity is -V0 (up is negative).
REQ-004 SHALL provide parameter GRAV_STEP, default 2, velocity increment applied at the end of each hold period.
REQ-005 SHALL provide parameter HOLD, default 2, frame ticks per velocity level (HOLD >= 1).
REQ-006 SHALL provide parameter V_MAX, default 10, terminal fall velocity.
REQ-007 SHALL provide parameter GROUND_Y, default 400, ground row.
REQ-008 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-009 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port frame_tick, input, 1, one-Clk pulse per frame that advances physics.
REQ-011 SHALL have port jump_req, input, 1, level-sensitive jump request from the key decoder.
REQ-012 SHALL have port velocity, output, VEL_W signed, current vertical velocity.
REQ-013 SHALL have port y_pos, output, Y_W, current vertical position.
REQ-014 SHALL have port on_ground, output, 1, high in IDLE and LAND.
REQ-015 SHALL have port landed, output, 1, one-Clk pulse on touchdown.
REQ-016 SHALL have port apex, output, 1, one-Clk pulse when rise ends.

Function
REQ-017 SHALL implement states IDLE, RISE, FALL, LAND, each with a HOLD-period counter hold_cnt.
REQ-018 SHALL change y_pos, velocity, hold_cnt and state only in cycles where frame_tick=1, except Reset and the double-jump pending flag.
REQ-019 IDLE: on a tick with jump_req=1, SHALL enter RISE with velocity=-V0 and hold_cnt=0, leaving y_pos unchanged.
REQ-020 RISE/FALL tick: SHALL set y_pos += velocity, then increment hold_cnt; at hold_cnt=HOLD-1 SHALL add GRAV_STEP to velocity and clear hold_cnt.
REQ-021 RISE: when the updated velocity is >= 0, SHALL set velocity=0, enter FALL and pulse apex in the same cycle.
REQ-022 Ceiling: if y_pos+velocity < 0 during RISE, SHALL clamp y_pos=0, set velocity=0, enter FALL and pulse apex.
REQ-023 FALL: SHALL saturate velocity at V_MAX.
REQ-024 FALL: if y_pos+velocity >= GROUND_Y, SHALL set y_pos=GROUND_Y and velocity=0, enter LAND and pulse landed; this check takes priority over the velocity update.
REQ-025 LAND: SHALL remain while jump_req=1 (held key never auto-rejumps), and on a tick with jump_req=0 SHALL go to IDLE.
REQ-026 Position arithmetic SHALL be done at Y_W+2 signed bits; no wrap-around is permitted on y_pos.
REQ-027 Reset asserted mid-jump SHALL abort immediately to IDLE with no landed pulse.

Reset
REQ-028 On Reset SHALL set state=IDLE, y_pos=GROUND_Y, velocity=0, hold_cnt=0, landed=0, apex=0, pending flag=0, edge register=0.
REQ-029 on_ground SHALL read 1 while Reset is held.

Configuration
REQ-030 Macro JUMP_DOUBLE_EN SHALL control double jump.
- Defined: a rising edge of jump_req in RISE/FALL sets a pending flag.
- On the next tick, if no double jump has been used this airtime, velocity=-V0, hold_cnt=0, state=RISE.
- The used-flag is cleared on entering LAND.
- A pending flag and a ground contact on the same tick resolve as landing.
REQ-031 Undefined: jump_req SHALL be ignored outside IDLE/LAND, and no edge or pending logic SHALL be synthesised.

Verification
REQ-032 Defaults, jump_req pulsed on tick 1 -> y_pos=390,380,372,364,358,352,348,344,342,340; apex on tick 11; landed on tick 23 with y_pos=400.
REQ-033 jump_req held through landing -> state stays LAND, no second launch; release then re-press relaunches with velocity=-10.
REQ-034 Reset asserted at y_pos=352 between ticks -> y_pos=400, velocity=0, on_ground=1 immediately, with no landed pulse.
REQ-035 GROUND_Y=30, V0=10 -> ceiling clamp y_pos=0, apex pulse, velocity=0.
REQ-036 V_MAX=4 -> fall velocity never exceeds 4; touchdown y_pos exactly GROUND_Y.
REQ-037 JUMP_DOUBLE_EN, second press at y_pos=344 -> velocity=-10 on next tick; a third press is ignored; without the macro the same stimulus is ignored.
